// File: rtl/cmd_prefetch_queue_pkg.sv
// Shared widths, FSM encoding and helpers for the command prefetch queue.
package cmd_prefetch_queue_pkg;

    localparam int CMD_WORD_W    = 32;
    localparam int CMD_MAX_WORDS = 3;
    localparam int CMD_WINDOW_W  = CMD_WORD_W * CMD_MAX_WORDS;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_READY = 2'd1,
        ST_GAP   = 2'd2
    } pq_state_t;

    // A zero command size from the decoder still consumes one word.
    function automatic logic [1:0] retire_words(input logic [1:0] cmd_size);
        return (cmd_size == 2'd0) ? 2'd1 : cmd_size;
    endfunction

endpackage

// File: rtl/cmd_word_fifo.sv
// Circular DEPTH x 32 word store with 0..3 word pop, flush and a look-ahead
// 3-word peek of the contents as they will be after this cycle's update.
module cmd_word_fifo
    import cmd_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [CMD_WORD_W-1:0]   wr_data,
    input  logic [1:0]              pop_n,
    output logic [CNT_W-1:0]        level_next,
    output logic [CMD_WINDOW_W-1:0] window_next
);

    logic [CMD_WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      head_nxt;
    logic [PTR_W-1:0]      idx;

    assign head_nxt   = head + PTR_W'(pop_n);
    assign level_next = flush ? '0 : count + CNT_W'(wr_en) - CNT_W'(pop_n);

    // The word being written this cycle bypasses storage so the window
    // register can capture it at the same edge.
    always_comb begin
        window_next = '0;
        idx         = '0;
        for (int i = 0; i < CMD_MAX_WORDS; i++) begin
            idx = head_nxt + PTR_W'(i);
            window_next[i*CMD_WORD_W +: CMD_WORD_W] = (wr_en && idx == tail) ? wr_data : mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            tail  <= head;
            count <= '0;
        end else begin
            if (wr_en) tail <= tail + PTR_W'(1);
            head  <= head_nxt;
            count <= level_next;
        end
    end

    // NOTE: storage is deliberately left out of reset; occupancy is tracked by
    // count, so stale words are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[tail] <= wr_data;
    end

endmodule

// File: rtl/cmd_prefetch_queue.sv
// Instruction prefetch queue: streams ROM words into a small FIFO and presents
// the three head words as a command window; retires and redirects on request.
module cmd_prefetch_queue
    import cmd_prefetch_queue_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic                    rom_rd,
    input  logic [CMD_WORD_W-1:0]   rom_data,
    output logic [CMD_WINDOW_W-1:0] cmd_arguments,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic                    exe_flag,
    input  logic [1:0]              cmd_size,
    input  logic                    ready_flag,
    input  logic                    jmp_flag,
    input  logic [31:0]             jmp_offset
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pq_state_t             state;
    logic                  in_flight;
    logic                  retire;
    logic                  push;
    logic                  in_flight_nxt;
    logic                  fetch_ok;
    logic [1:0]            pop_n;
    logic [CNT_W-1:0]      level_next;
    logic [CMD_WINDOW_W-1:0] window_next;
    logic [ADDR_W-1:0]     jmp_target;
    logic                  unused_offset_bits;

    assign unused_offset_bits = ^jmp_offset[31:ADDR_W];

    // A jump overrides a simultaneous retire; the returning read is dropped.
    assign retire        = (state == ST_READY) && ready_flag && !jmp_flag;
    assign pop_n         = retire ? retire_words(cmd_size) : 2'd0;
    assign push          = in_flight && !jmp_flag;
    assign in_flight_nxt = rom_rd && !jmp_flag;
    assign jmp_target    = cmd_addr + jmp_offset[ADDR_W-1:0];
    // Reserve room for the read about to be issued and the one still returning.
    assign fetch_ok      = !jmp_flag && ((int'(level_next) + int'(in_flight_nxt)) < DEPTH);

    cmd_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (jmp_flag),
        .wr_en       (push),
        .wr_data     (rom_data),
        .pop_n       (pop_n),
        .level_next  (level_next),
        .window_next (window_next)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr      <= ADDR_W'(RESET_ADDR);
            rom_rd        <= 1'b0;
            in_flight     <= 1'b0;
            cmd_addr      <= ADDR_W'(RESET_ADDR);
            cmd_arguments <= '0;
            exe_flag      <= 1'b0;
            state         <= ST_FILL;
        end else if (jmp_flag) begin
            rom_addr  <= jmp_target;
            cmd_addr  <= jmp_target;
            rom_rd    <= 1'b0;
            in_flight <= 1'b0;
            exe_flag  <= 1'b0;
            state     <= ST_FILL;
        end else begin
            if (rom_rd) rom_addr <= rom_addr + ADDR_W'(1);
            rom_rd    <= fetch_ok;
            in_flight <= in_flight_nxt;
            cmd_addr  <= cmd_addr + ADDR_W'(pop_n);
            if (push || retire) cmd_arguments <= window_next;

            case (state)
                ST_FILL: begin
                    if (level_next >= CNT_W'(CMD_MAX_WORDS)) begin
                        state    <= ST_READY;
                        exe_flag <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (retire) begin
                        state    <= ST_GAP;
                        exe_flag <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (level_next >= CNT_W'(CMD_MAX_WORDS)) begin
                        state    <= ST_READY;
                        exe_flag <= 1'b1;
                    end else begin
                        state    <= ST_FILL;
                        exe_flag <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    exe_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_prefetch_queue.md
Name: cmd_prefetch_queue

Overview:
Word-granular instruction prefetch queue between program ROM and the decoder/executor pair. Streams 32-bit command words from a synchronous ROM into a small circular FIFO and presents the three head words as a 96-bit command window with a valid strobe. It retires 1..3 words per executed command and flushes/redirects on a relative jump. Sits directly upstream of decoder and executor; ROM is external.

Parameters:
ADDR_W, 8, ROM word-address width; all address arithmetic is modulo 2^ADDR_W
DEPTH, 4, FIFO depth in 32-bit words; power of two, >= 4
RESET_ADDR, 0, word address of first command after reset

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  ROM word address
rom_rd  out  1  ROM read strobe; data returns on rom_data exactly 1 cycle later
rom_data  in  32  ROM read data
cmd_arguments  out  96  window: [31:0] head word, [63:32] head+1, [95:64] head+2, unmodified ROM order
cmd_addr  out  ADDR_W  word address of head word (current command)
exe_flag  out  1  window valid, command may execute
cmd_size  in  2  words in current command, from decoder; 0 treated as 1
ready_flag  in  1  1-cycle pulse: executor done, retire cmd_size words
jmp_flag  in  1  1-cycle pulse: redirect, flush queue
jmp_offset  in  32  signed word offset relative to cmd_addr

Behaviour:
- Reset (async, rst_n low): rom_addr=RESET_ADDR, rom_rd=0, cmd_arguments=0, cmd_addr=RESET_ADDR, exe_flag=0, count=0, in-flight=0, state=FILL.
- Fetch: rom_rd=1 in any cycle where count + in_flight < DEPTH and no jmp_flag; rom_addr post-increments by 1 per issued read, wraps 2^ADDR_W-1 -> 0. Back-to-back reads allowed (in_flight 0..1).
- Response: rom_data written at tail on the cycle after an issued, non-cancelled read; count+1.
- Window: cmd_arguments registered from FIFO head..head+2; updates the cycle after any push/pop.
- States: FILL (count<3, exe_flag=0) -> READY when count>=3; READY (exe_flag=1) holds until ready_flag or jmp_flag; GAP (exe_flag=0 for exactly one cycle after retire or jump) -> READY if count>=3 else FILL.
- Retire: on ready_flag in READY, pop n=max(cmd_size,1) words (n=3 max), cmd_addr += n mod 2^ADDR_W. ready_flag outside READY ignored.
- Jump: on jmp_flag (any state), count=0, any read returning next cycle discarded, no read issued that cycle, rom_addr=cmd_addr+jmp_offset[ADDR_W-1:0] (mod), cmd_addr same value; next state FILL. First read of new stream the cycle after.
- Simultaneous ready_flag and jmp_flag: jump wins, no pop applied; offset relative to pre-retire cmd_addr.
- Push and pop same cycle: count = count + 1 - n; never overflows since fetch gate counts in-flight read.
- Full (count+in_flight=DEPTH): rom_rd held 0, rom_addr stable.
- Latency from reset release: first rom_rd cycle 1; exe_flag first high 5 cycles after reset release with ROM latency 1 (3 reads + write + window register).

Decomposition:
- Shared package: CMD_WORD_W=32, CMD_MAX_WORDS=3, CMD_WINDOW_W=96, state encoding (FILL, READY, GAP).
- One sub-module: cmd_word_fifo (circular DEPTH x 32 storage, head/tail pointers, 1-3 word pop, 3-word peek); control FSM and ROM addressing stay in cmd_prefetch_queue.

Test Plan:
- Reset, ROM word k = 0x1000_0000+k, executor idle -> exe_flag rises, cmd_arguments = {0x10000002,0x10000001,0x10000000}, cmd_addr=0, rom_rd stops when count+in_flight=4.
- ready_flag with cmd_size=2 -> exe_flag low one cycle, then window {0x10000004,0x10000003,0x10000002}, cmd_addr=2; cmd_size=0 retires 1 word.
- At cmd_addr=5, jmp_flag, jmp_offset=-5 (0xFFFFFFFB) -> stale response dropped, rom_addr restarts at 0, window returns to words 0..2, cmd_addr=0.
- ADDR_W=8, cmd_addr=0xFE, retire 3 -> cmd_addr=0x01, window built from wrapped words 0x01..0x03, no stall beyond refill.
- ready_flag and jmp_flag same cycle at cmd_addr=4, offset +10 -> no pop, cmd_addr=14; rst_n low mid-refill -> all outputs at reset values same cycle (async).
